// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N-channel, W-bit registered arbitrating mux. Each cycle one
//               requesting channel is chosen, either round-robin starting at
//               a rotating pointer or fixed priority (lowest index wins).
//               The chosen word and its channel index are captured in a
//               single output register with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
  parameter int N  = 4,   // number of input channels (>= 2, any value)
  parameter int W  = 16,  // data width per channel
  parameter int SW = 2    // channel index width, 2**SW >= N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,       // 0 = round-robin, 1 = fixed priority
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  // Index of the highest channel; the pointer wraps back to zero after it.
  localparam logic [SW-1:0] c_LAST_IDX = SW'(N - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_ptr;        // first channel examined by the round-robin scan

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic [W-1:0]  w_chan_data [N];
  logic [N-1:0]  w_upper_mask;   // channels at or above the pointer
  logic [N-1:0]  w_upper_req;
  logic [SW-1:0] w_rr_grant;
  logic [SW-1:0] w_fp_grant;
  logic [SW-1:0] w_grant;
  logic          w_gvalid;
  logic          w_load;         // output slot empty or draining this cycle
  logic          w_take;         // a word is captured at the next edge
  logic [SW-1:0] w_next_ptr;
  logic [W-1:0]  w_sel_data;

  // Lowest set bit of a request vector; zero when nothing is set, which is
  // harmless because every consumer of the result is qualified by gvalid.
  function automatic logic [SW-1:0] f_lowest(input logic [N-1:0] req);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = SW'(i);
      end
    end
    return idx;
  endfunction

  // Split the flat data bus into per-channel words.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_chan_data[gi] = in_data[gi*W +: W];
  end

  // Mark channels whose index is at or beyond the pointer for the cyclic scan.
  always_comb begin
    w_upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_upper_mask[i] = (SW'(i) >= r_ptr);
    end
  end

  // The cyclic scan ptr..N-1,0..ptr-1 is the lowest requester at/above the
  // pointer if one exists, otherwise the lowest requester overall. This holds
  // for any N, so no power-of-two rotation is needed.
  assign w_upper_req = in_valid & w_upper_mask;
  assign w_rr_grant  = (|w_upper_req) ? f_lowest(w_upper_req) : f_lowest(in_valid);
  assign w_fp_grant  = f_lowest(in_valid);
  assign w_grant     = mode ? w_fp_grant : w_rr_grant;
  assign w_gvalid    = |in_valid;

  assign w_load      = !r_out_valid || out_ready;
  assign w_take      = w_load && w_gvalid;

  // Pointer moves one past the winner, wrapping explicitly at N-1 so that a
  // non-power-of-two channel count never produces an out-of-range index.
  assign w_next_ptr  = (w_grant == c_LAST_IDX) ? '0 : w_grant + 1'b1;

  // Only the granted channel's word is routed; other channels' data is never
  // looked at, so unknown values there cannot reach the output register.
  assign w_sel_data  = w_chan_data[w_grant];

  // One-hot accept to the granted channel, forced low while in reset.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = rst_n && w_take && (w_grant == SW'(gi));
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Output register: capture on load with a request, empty on load without
  // one (data/index kept), hold everything under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      if (w_gvalid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on round-robin grants; fixed-priority
  // periods leave it untouched so rotation resumes where it stopped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_take && !mode) begin
      r_ptr <= w_next_ptr;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire
